dec_pipe: RTL and testbench

- Parametrised, registered instruction-decode pipeline stage for the CSE141L core.
- Takes a full instruction word, whose opcode is in the top bits. Extracts the register fields and the branch amount by instruction class, and sets the write enables.
- Holds the result in a one-entry output register with valid/ready handshakes on both sides.
- Stalls upstream on load-use hazards, supports a synchronous flush, and counts stall cycles.

---
 rtl/dec_pipe_if.sv | 34 +++
 rtl/dec_pipe.sv | 150 +++++++++++++++
 tb/tb_dec_pipe.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dec_pipe_if.sv
// Handshake and decoded-bundle signals between the fetch side, the decode stage
// and the execute side.
interface dec_pipe_if #(
   parameter int INST_W = 20,
   parameter int OP_W   = 5,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [INST_W-1:0]        inst;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [OP_W-1:0]          op;
   logic [REG_W-1:0]         rs;
   logic [REG_W-1:0]         rt;
   logic [REG_W-1:0]         rd;
   logic [INST_W-OP_W-1:0]   bamt;
   logic                     we_rf;
   logic                     we_dmem;
   logic                     is_load;
   logic [CNT_W-1:0]         stall_cnt;

   modport slave (
      input  in_valid, inst, flush, out_ready,
      output in_ready, out_valid, op, rs, rt, rd, bamt, we_rf, we_dmem, is_load, stall_cnt
   );

   modport master (
      output in_valid, inst, flush, out_ready,
      input  in_ready, out_valid, op, rs, rt, rd, bamt, we_rf, we_dmem, is_load, stall_cnt
   );
endinterface

// File: rtl/dec_pipe.sv
// Registered instruction-decode stage: field extraction by class, one-entry output
// register with valid/ready, load-use stall, synchronous flush and stall counter.
module dec_pipe #(
   parameter int INST_W  = 20,
   parameter int OP_W    = 5,
   parameter int REG_W   = 5,
   parameter int OP_RMAX = 7,
   parameter int OP_RX   = 11,
   parameter int OP_LD   = 12,
   parameter int OP_ST   = 13,
   parameter int LD_LAT  = 1,
   parameter int CNT_W   = 16
) (
   input logic        clk,
   input logic        rst_n,
   dec_pipe_if.slave  bus
);
   localparam int B = INST_W - OP_W;
   localparam logic [OP_W-1:0] OPC_RMAX = OP_W'(OP_RMAX);
   localparam logic [OP_W-1:0] OPC_RX   = OP_W'(OP_RX);
   localparam logic [OP_W-1:0] OPC_LD   = OP_W'(OP_LD);
   localparam logic [OP_W-1:0] OPC_ST   = OP_W'(OP_ST);

   logic [OP_W-1:0]  op_in;
   logic [REG_W-1:0] f2, f1, f0;
   logic             cls_r, cls_ld, cls_st;

   logic [REG_W-1:0] d_rs, d_rt, d_rd;
   logic [B-1:0]     d_bamt;
   logic             d_we_rf, d_we_dmem, d_is_load;

   logic             src_hit, hz, in_ready_c, cap;

   logic             out_valid_q;
   logic [OP_W-1:0]  op_q;
   logic [REG_W-1:0] rs_q, rt_q, rd_q;
   logic [B-1:0]     bamt_q;
   logic             we_rf_q, we_dmem_q, is_load_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [2:0]       hcnt;
   logic [REG_W-1:0] ld_rd;

   assign op_in  = bus.inst[INST_W-1 -: OP_W];
   assign f2     = bus.inst[3*REG_W-1:2*REG_W];
   assign f1     = bus.inst[2*REG_W-1:REG_W];
   assign f0     = bus.inst[REG_W-1:0];
   assign cls_r  = (op_in < OPC_RMAX) || (op_in == OPC_RX);
   assign cls_ld = (op_in == OPC_LD);
   assign cls_st = (op_in == OPC_ST);

   always_comb begin
      d_rs      = '0;
      d_rt      = '0;
      d_rd      = '0;
      d_bamt    = '0;
      d_we_rf   = 1'b0;
      d_we_dmem = 1'b0;
      d_is_load = 1'b0;
      if (cls_r) begin
         d_rd    = f2;
         d_rs    = f1;
         d_rt    = f0;
         d_we_rf = 1'b1;
      end else if (cls_ld) begin
         d_rd      = f2;
         d_rt      = f1;
         d_rs      = f0;
         d_we_rf   = 1'b1;
         d_is_load = 1'b1;
      end else if (cls_st) begin
         d_rs      = f2;
         d_rd      = f1;
         d_we_dmem = 1'b1;
      end else begin
         d_bamt = bus.inst[B-1:0];
      end
   end

   // Only the registers the instruction actually reads count; register 0 is compared too.
   always_comb begin
      src_hit = 1'b0;
      if (cls_r)
         src_hit = (d_rs == ld_rd) || (d_rt == ld_rd);
      else if (cls_ld)
         src_hit = (d_rs == ld_rd);
      else if (cls_st)
         src_hit = (d_rs == ld_rd) || (d_rd == ld_rd);
   end

   assign hz         = (hcnt != 3'd0) && bus.in_valid && src_hit;
   assign in_ready_c = (!out_valid_q || bus.out_ready) && !hz && !bus.flush;
   assign cap        = bus.in_valid && in_ready_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         op_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         bamt_q      <= '0;
         we_rf_q     <= 1'b0;
         we_dmem_q   <= 1'b0;
         is_load_q   <= 1'b0;
         stall_cnt_q <= '0;
         hcnt        <= 3'd0;
         ld_rd       <= '0;
      end else begin
         // A flush cycle is not counted as a stall even if a hazard is present.
         if (bus.in_valid && hz && !bus.flush && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (bus.flush) begin
            out_valid_q <= 1'b0;
            hcnt        <= 3'd0;
         end else begin
            if (cap) begin
               out_valid_q <= 1'b1;
               op_q        <= op_in;
               rs_q        <= d_rs;
               rt_q        <= d_rt;
               rd_q        <= d_rd;
               bamt_q      <= d_bamt;
               we_rf_q     <= d_we_rf;
               we_dmem_q   <= d_we_dmem;
               is_load_q   <= d_is_load;
            end else if (bus.out_ready) begin
               out_valid_q <= 1'b0;
            end
            if (cap && d_is_load) begin
               ld_rd <= d_rd;
               hcnt  <= 3'(LD_LAT);
            end else if (hcnt != 3'd0) begin
               hcnt <= hcnt - 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.op        = op_q;
   assign bus.rs        = rs_q;
   assign bus.rt        = rt_q;
   assign bus.rd        = rd_q;
   assign bus.bamt      = bamt_q;
   assign bus.we_rf     = we_rf_q;
   assign bus.we_dmem   = we_dmem_q;
   assign bus.is_load   = is_load_q;
   assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_dec_pipe.sv
// Bench for dec_pipe: table of instructions with expected bundles, scoreboard queue,
// plus hand sequences for load-use, backpressure, flush and async reset.
module tb_dec_pipe;
   typedef struct {
      logic [19:0] inst;
      logic [4:0]  rd, rs, rt;
      logic [14:0] bamt;
      logic        we_rf, we_dmem, is_load;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dec_pipe_if #(.INST_W(20), .OP_W(5), .REG_W(5), .CNT_W(16)) bus ();

   dec_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   errors = 0;
   int   checks = 0;
   vec_t q[$];
   vec_t cur;
   vec_t tbl[11];
   logic last_acc;
   logic last_rdy;

   function automatic vec_t mk(input logic [19:0] i, input logic [4:0] rd, rs, rt,
                               input logic [14:0] bm, input logic wr, wm, ld);
      vec_t v;
      v.inst = i; v.rd = rd; v.rs = rs; v.rt = rt; v.bamt = bm;
      v.we_rf = wr; v.we_dmem = wm; v.is_load = ld;
      return v;
   endfunction

   function automatic logic [63:0] pack_exp(input vec_t v);
      return 64'({v.inst[19:15], v.rd, v.rs, v.rt, v.bamt, v.we_rf, v.we_dmem, v.is_load});
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample at the falling edge, settle inputs 1ns after the rising edge.
   task automatic cyc();
      logic acc, drn;
      vec_t e;
      @(negedge clk);
      acc      = bus.in_valid && bus.in_ready;
      drn      = bus.out_valid && bus.out_ready;
      last_rdy = bus.in_ready;
      if (drn) begin
         if (q.size() == 0) begin
            chk("spurious_out", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            chk("bundle", 64'({bus.op, bus.rd, bus.rs, bus.rt, bus.bamt,
                               bus.we_rf, bus.we_dmem, bus.is_load}), pack_exp(e));
         end
      end else if (bus.flush && bus.out_valid && q.size() > 0) begin
         void'(q.pop_front());
      end
      if (acc) q.push_back(cur);
      last_acc = acc;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v, input bit rnd, output int waits);
      cur          = v;
      bus.inst     = v.inst;
      bus.in_valid = 1'b1;
      waits        = 0;
      last_acc     = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
         cyc();
         if (last_acc) break;
         waits++;
      end
      if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int w;
      logic [15:0] s0;
      vec_t va, vb;

      tbl[0]  = mk(20'h19041, 5'd4,  5'd2, 5'd1,  15'h0,    1, 0, 0);
      tbl[1]  = mk(20'h6A8A0, 5'd5,  5'd10, 5'd0, 15'h0,    0, 1, 0);
      tbl[2]  = mk(20'hA1234, 5'd0,  5'd0, 5'd0,  15'h1234, 0, 0, 0);
      tbl[3]  = mk(20'h61403, 5'd5,  5'd3, 5'd0,  15'h0,    1, 0, 1);
      tbl[4]  = mk(20'h098A2, 5'd6,  5'd5, 5'd2,  15'h0,    1, 0, 0);
      tbl[5]  = mk(20'h098C2, 5'd6,  5'd6, 5'd2,  15'h0,    1, 0, 0);
      tbl[6]  = mk(20'h59D09, 5'd7,  5'd8, 5'd9,  15'h0,    1, 0, 0);
      tbl[7]  = mk(20'h3FFFF, 5'd0,  5'd0, 5'd0,  15'h7FFF, 0, 0, 0);
      tbl[8]  = mk(20'h37C1F, 5'd31, 5'd0, 5'd31, 15'h0,    1, 0, 0);
      tbl[9]  = mk(20'hF8001, 5'd0,  5'd0, 5'd0,  15'h0001, 0, 0, 0);
      tbl[10] = mk(20'h00421, 5'd1,  5'd1, 5'd1,  15'h0,    1, 0, 0);

      bus.in_valid  = 1'b0;
      bus.inst      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      cur           = tbl[0];
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
      chk("rst_fields", 64'({bus.op, bus.rd, bus.rs, bus.rt, bus.bamt,
                             bus.we_rf, bus.we_dmem, bus.is_load}), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Full-rate pass: only the load-dependent entry may wait, and exactly one cycle.
      for (int i = 0; i < 11; i++) begin
         send(tbl[i], 1'b0, w);
         chk($sformatf("pass1_waits_%0d", i), 64'(w), (i == 4) ? 64'd1 : 64'd0);
      end
      drain();
      chk("pass1_stall_cnt", 64'(bus.stall_cnt), 64'd1);

      for (int i = 0; i < 11; i++) send(tbl[i], 1'b1, w);
      drain();

      // Load-use with dependent rs=5, then with rs=6.
      s0 = bus.stall_cnt;
      send(tbl[3], 1'b0, w);
      send(tbl[4], 1'b0, w);
      chk("lduse_waits", 64'(w), 64'd1);
      chk("lduse_stall_cnt", 64'(bus.stall_cnt), 64'(s0 + 16'd1));
      send(tbl[3], 1'b0, w);
      send(tbl[5], 1'b0, w);
      chk("nodep_waits", 64'(w), 64'd0);
      chk("nodep_stall_cnt", 64'(bus.stall_cnt), 64'(s0 + 16'd1));
      drain();

      // Backpressure: held bundle stays put, second instruction waits.
      va = tbl[0];
      vb = tbl[6];
      bus.out_ready = 1'b0;
      send(va, 1'b0, w);
      cur = vb; bus.inst = vb.inst; bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("bp_in_ready", 64'(last_rdy), 64'd0);
         chk("bp_hold", 64'({bus.out_valid, bus.rd, bus.rs, bus.rt}),
             64'({1'b1, va.rd, va.rs, va.rt}));
      end
      bus.out_ready = 1'b1;
      cyc();
      chk("bp_accept", 64'(last_acc), 64'd1);
      drain();

      // Flush during the load-use stall.
      s0 = bus.stall_cnt;
      send(tbl[3], 1'b0, w);
      cur = tbl[4]; bus.inst = tbl[4].inst; bus.in_valid = 1'b1; bus.flush = 1'b1;
      cyc();
      chk("flush_no_cap", 64'(last_acc), 64'd0);
      bus.flush = 1'b0;
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      send(tbl[4], 1'b0, w);
      chk("flush_dep_waits", 64'(w), 64'd0);
      chk("flush_stall_cnt", 64'(bus.stall_cnt), 64'(s0));
      drain();

      // Async reset in the middle of a stall cycle.
      send(tbl[3], 1'b0, w);
      cur = tbl[4]; bus.inst = tbl[4].inst; bus.in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_stall_cnt", 64'(bus.stall_cnt), 64'd0);
      bus.in_valid = 1'b0;
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc();
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      send(tbl[4], 1'b0, w);
      chk("post_rst_waits", 64'(w), 64'd0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
